// File: rtl/bmu_pkg.sv
// rtl/bmu_pkg.sv - shared types and helpers for the bmu_pipe bit-manipulation unit
//
// Purpose : decoded operation packet, its width, and the one-hot legality check.
// Ports   : none (package).
// Macro   : BMU_PACK_EN does not change this file; the pack/packu/packh bits are
//           always present so the decode interface is the same in every build.

package bmu_pkg;

  // Field order fixes the packed bit layout: unsign is bit 0, the op bits sit above it.
  typedef struct packed {
    logic clz, ctz, cpop;
    logic min, max;
    logic rol, ror;
    logic land, lor, lxor;
    logic sh1add, sh2add, sh3add;
    logic bset, bclr, binv, bext;
    logic siext_b, siext_h;
    logic add, sub, slt;
    logic sll, srl, sra;
    logic pack, packu, packh;
    logic unsign;
  } bmu_op_pkt_t;

  localparam int BMU_OP_W = $bits(bmu_op_pkt_t);

  // True when exactly one op bit is set; unsign is a modifier and is ignored.
  function automatic logic bmu_onehot_chk(input bmu_op_pkt_t op);
    logic [BMU_OP_W-2:0] v;
    v = op[BMU_OP_W-1:1];
    return (v != '0) && ((v & (v - (BMU_OP_W-1)'(1))) == '0);
  endfunction

endpackage

// File: rtl/bmu_bitcnt.sv
// rtl/bmu_bitcnt.sv - combinational leading/trailing zero count and popcount
//
// Purpose : clz, ctz and cpop of one XLEN-wide operand; a zero operand gives XLEN
//           for both zero counts.
// Ports   : i_a     operand
//           o_clz   leading zero count  (SHW+1 bits)
//           o_ctz   trailing zero count (SHW+1 bits)
//           o_cpop  number of set bits  (SHW+1 bits)

module bmu_bitcnt #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0]          i_a,
  output logic [$clog2(XLEN):0]    o_clz,
  output logic [$clog2(XLEN):0]    o_ctz,
  output logic [$clog2(XLEN):0]    o_cpop
);

  localparam int SHW = $clog2(XLEN);

  always_comb begin
    o_clz  = (SHW+1)'(XLEN);
    o_ctz  = (SHW+1)'(XLEN);
    o_cpop = '0;
    // Ascending scan: the highest set bit is the last to write clz.
    for (int i = 0; i < XLEN; i++) begin
      if (i_a[i]) o_clz = (SHW+1)'(XLEN - 1 - i);
      o_cpop = o_cpop + (SHW+1)'(i_a[i]);
    end
    // Descending scan: the lowest set bit is the last to write ctz.
    for (int i = XLEN - 1; i >= 0; i--) begin
      if (i_a[i]) o_ctz = (SHW+1)'(i);
    end
  end

endmodule

// File: rtl/bmu_pipe.sv
// rtl/bmu_pipe.sv - two-stage pipelined bit-manipulation execution unit
//
// Purpose : S1 registers and decodes a request (one-hot check, shift-amount
//           masking); S2 registers the computed result. Valid/ready on both sides,
//           flush kills everything in flight, illegal ops return error with result 0.
// Macro   : BMU_PACK_EN enables pack/packu/packh; when undefined those ops are errors.
// Ports   : clk, rst        clock, asynchronous active-high reset
//           in_valid/ready  request handshake
//           in_op           one-hot op bits plus unsign modifier
//           in_a, in_b      operands (rs1, rs2/immediate)
//           flush           drop all in-flight ops at the next edge
//           out_valid/ready result handshake
//           out_result      XLEN-bit result
//           out_error       illegal / non-one-hot op

module bmu_pipe
  import bmu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  bmu_op_pkt_t       in_op,
  input  logic [XLEN-1:0]   in_a,
  input  logic [XLEN-1:0]   in_b,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_result,
  output logic              out_error
);

  localparam int SHW = $clog2(XLEN);

  // Stage 1 state
  logic              r_s1_valid;
  bmu_op_pkt_t       r_s1_op;
  logic [XLEN-1:0]   r_s1_a;
  logic [XLEN-1:0]   r_s1_b;
  logic [SHW-1:0]    r_s1_sh;
  logic              r_s1_err;

  // Stage 2 state
  logic              r_s2_valid;
  logic [XLEN-1:0]   r_s2_result;
  logic              r_s2_err;

  // Handshake
  logic              w_s2_ready;
  logic              w_s1_ready;
  logic              w_accept;
  logic              w_s1_adv;

  // Decode / datapath
  logic              w_in_err;
  logic [SHW:0]      w_clz;
  logic [SHW:0]      w_ctz;
  logic [SHW:0]      w_cpop;
  logic [SHW-1:0]    w_neg_sh;
  logic [XLEN-1:0]   w_bitmask;
  logic              w_lt;
  logic [XLEN-1:0]   w_res;

  assign w_s2_ready = !r_s2_valid || out_ready;
  assign w_s1_ready = !r_s1_valid || w_s2_ready;
  assign in_ready   = w_s1_ready;
  assign w_accept   = in_valid && w_s1_ready;
  assign w_s1_adv   = r_s1_valid && w_s2_ready;

  always_comb begin
    w_in_err = !bmu_onehot_chk(in_op);
`ifdef BMU_PACK_EN
    // pack/packu/packh are legal ops in this build.
`else
    if (in_op.pack || in_op.packu || in_op.packh) w_in_err = 1'b1;
`endif
  end

  bmu_bitcnt #(.XLEN(XLEN)) u_bitcnt (
    .i_a    (r_s1_a),
    .o_clz  (w_clz),
    .o_ctz  (w_ctz),
    .o_cpop (w_cpop)
  );

  // Rotations use the complementary amount mod XLEN; at sh=0 both halves equal A.
  assign w_neg_sh  = -r_s1_sh;
  assign w_bitmask = {{(XLEN-1){1'b0}}, 1'b1} << r_s1_sh;
  assign w_lt      = r_s1_op.unsign ? (r_s1_a < r_s1_b)
                                    : ($signed(r_s1_a) < $signed(r_s1_b));

  always_comb begin
    w_res = '0;
    if (!r_s1_err) begin
      case (1'b1)
        r_s1_op.clz:     w_res = {{(XLEN-SHW-1){1'b0}}, w_clz};
        r_s1_op.ctz:     w_res = {{(XLEN-SHW-1){1'b0}}, w_ctz};
        r_s1_op.cpop:    w_res = {{(XLEN-SHW-1){1'b0}}, w_cpop};
        r_s1_op.min:     w_res = w_lt ? r_s1_a : r_s1_b;
        r_s1_op.max:     w_res = w_lt ? r_s1_b : r_s1_a;
        r_s1_op.rol:     w_res = (r_s1_a << r_s1_sh) | (r_s1_a >> w_neg_sh);
        r_s1_op.ror:     w_res = (r_s1_a >> r_s1_sh) | (r_s1_a << w_neg_sh);
        r_s1_op.land:    w_res = r_s1_a & r_s1_b;
        r_s1_op.lor:     w_res = r_s1_a | r_s1_b;
        r_s1_op.lxor:    w_res = r_s1_a ^ r_s1_b;
        r_s1_op.sh1add:  w_res = {r_s1_a[XLEN-2:0], 1'b0} + r_s1_b;
        r_s1_op.sh2add:  w_res = {r_s1_a[XLEN-3:0], 2'b0} + r_s1_b;
        r_s1_op.sh3add:  w_res = {r_s1_a[XLEN-4:0], 3'b0} + r_s1_b;
        r_s1_op.bset:    w_res = r_s1_a | w_bitmask;
        r_s1_op.bclr:    w_res = r_s1_a & ~w_bitmask;
        r_s1_op.binv:    w_res = r_s1_a ^ w_bitmask;
        r_s1_op.bext:    w_res = {{(XLEN-1){1'b0}}, r_s1_a[r_s1_sh]};
        r_s1_op.siext_b: w_res = {{(XLEN-8){r_s1_a[7]}}, r_s1_a[7:0]};
        r_s1_op.siext_h: w_res = {{(XLEN-16){r_s1_a[15]}}, r_s1_a[15:0]};
        r_s1_op.add:     w_res = r_s1_a + r_s1_b;
        r_s1_op.sub:     w_res = r_s1_a - r_s1_b;
        r_s1_op.slt:     w_res = {{(XLEN-1){1'b0}}, w_lt};
        r_s1_op.sll:     w_res = r_s1_a << r_s1_sh;
        r_s1_op.srl:     w_res = r_s1_a >> r_s1_sh;
        r_s1_op.sra:     w_res = $signed(r_s1_a) >>> r_s1_sh;
`ifdef BMU_PACK_EN
        r_s1_op.pack:    w_res = {r_s1_b[XLEN/2-1:0], r_s1_a[XLEN/2-1:0]};
        r_s1_op.packu:   w_res = {r_s1_b[XLEN-1:XLEN/2], r_s1_a[XLEN-1:XLEN/2]};
        r_s1_op.packh:   w_res = {{(XLEN-16){1'b0}}, r_s1_b[7:0], r_s1_a[7:0]};
`else
`endif
        default:         w_res = '0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid  <= 1'b0;
      r_s1_op     <= '0;
      r_s1_a      <= '0;
      r_s1_b      <= '0;
      r_s1_sh     <= '0;
      r_s1_err    <= 1'b0;
      r_s2_valid  <= 1'b0;
      r_s2_result <= '0;
      r_s2_err    <= 1'b0;
    end else if (flush) begin
      // Flush wins over any same-cycle accept or advance.
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
    end else begin
      if (w_s1_ready) r_s1_valid <= in_valid;
      if (w_accept) begin
        r_s1_op  <= in_op;
        r_s1_a   <= in_a;
        r_s1_b   <= in_b;
        r_s1_sh  <= in_b[SHW-1:0];
        r_s1_err <= w_in_err;
      end
      // S2 reloads in the same cycle its result is taken, so no bubble.
      if (w_s2_ready) r_s2_valid <= r_s1_valid;
      if (w_s1_adv) begin
        r_s2_result <= w_res;
        r_s2_err    <= r_s1_err;
      end
    end
  end

  assign out_valid  = r_s2_valid;
  assign out_result = r_s2_result;
  assign out_error  = r_s2_err;

endmodule

// File: tb/tb_bmu_pipe.sv
// tb/tb_bmu_pipe.sv - directed self-checking bench for bmu_pipe (XLEN=32)

module tb_bmu_pipe;
  import bmu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  bmu_op_pkt_t in_op;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_error;

  int n_vec = 0;
  int n_err = 0;

  bmu_pipe #(.XLEN(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_a       (in_a),
    .in_b       (in_b),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_error  (out_error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One request with out_ready high; result must appear exactly two cycles after accept.
  task automatic run_one(input string tag, input bmu_op_pkt_t op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_res, input logic exp_err);
    @(negedge clk);
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b;
    #1 chk({tag, "_rdy"}, in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    #1 chk({tag, "_lat1"}, out_valid, 0);
    @(negedge clk);
    #1;
    chk({tag, "_vld"}, out_valid, 1);
    chk({tag, "_res"}, out_result, exp_res);
    chk({tag, "_err"}, out_error, exp_err);
  endtask

  task automatic drive(input bmu_op_pkt_t op, input logic [31:0] a, input logic [31:0] b);
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b;
  endtask

  bmu_op_pkt_t o;
  bmu_op_pkt_t o_add;
  int acc;
  int got;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_op = '0; in_a = '0; in_b = '0;
    flush = 1'b0; out_ready = 1'b1;
    o_add = '0; o_add.add = 1'b1;

    repeat (2) @(negedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_result", out_result, 0);
    chk("rst_out_error", out_error, 0);
    rst = 1'b0;

    o = '0; o.clz = 1'b1;  run_one("clz_zero", o, 32'h0000_0000, 0, 32, 0);
    o = '0; o.clz = 1'b1;  run_one("clz_b16",  o, 32'h0001_0000, 0, 15, 0);
    o = '0; o.ctz = 1'b1;  run_one("ctz_b31",  o, 32'h8000_0000, 0, 31, 0);
    o = '0; o.cpop = 1'b1; run_one("cpop",     o, 32'hF0F0_0001, 0, 9, 0);
    o = '0; o.min = 1'b1;  run_one("min_s",    o, 32'hFFFF_FFFF, 1, 32'hFFFF_FFFF, 0);
    o.unsign = 1'b1;       run_one("min_u",    o, 32'hFFFF_FFFF, 1, 1, 0);
    o = '0; o.sh3add = 1'b1; run_one("sh3add", o, 3, 5, 29, 0);
    o = '0; o.ror = 1'b1;  run_one("ror",      o, 1, 32'h21, 32'h8000_0000, 0);
    o = '0; o.rol = 1'b1;  run_one("rol",      o, 32'h8000_0001, 1, 3, 0);
    o = '0; o.sra = 1'b1;  run_one("sra",      o, 32'h8000_0000, 4, 32'hF800_0000, 0);
    o = '0; o.bext = 1'b1; run_one("bext",     o, 32'h10, 32'h24, 1, 0);
    o = '0; o.siext_b = 1'b1; run_one("siext_b", o, 32'h80, 0, 32'hFFFF_FF80, 0);
    o = '0; o.sub = 1'b1;  run_one("sub",      o, 5, 7, 32'hFFFF_FFFE, 0);
    o = '0; o.slt = 1'b1;  run_one("slt_s",    o, 32'hFFFF_FFFF, 1, 1, 0);
    o.unsign = 1'b1;       run_one("slt_u",    o, 32'hFFFF_FFFF, 1, 0, 0);
    o = '0; o.land = 1'b1; o.lor = 1'b1; run_one("err_two", o, 32'hFF, 32'h0F, 0, 1);
    o = '0;                run_one("err_zero", o, 32'hFF, 32'h0F, 0, 1);

    // Back-pressure: out_ready low for 5 cycles while streaming 4 adds.
    acc = 0; got = 0;
    for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
      @(negedge clk);
      out_ready = (cyc >= 5);
      if (acc < 4) drive(o_add, 32'(acc), 100);
      else in_valid = 1'b0;
      #1;
      if (cyc == 2) chk("bp_in_ready_drop", in_ready, 0);
      if (cyc >= 2 && cyc <= 4) chk("bp_hold", out_result, 100);
      if (cyc == 4) chk("bp_acc2", acc, 2);
      if (out_valid && out_ready) begin
        chk("bp_order", out_result, 32'(100 + got));
        got++;
      end
      if (in_valid && in_ready) acc++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    chk("bp_count", got, 4);
    repeat (2) begin
      @(negedge clk);
      #1 chk("bp_no_dup", out_valid, 0);
    end

    // Flush on the cycle after two back-to-back accepts, alongside a third request.
    @(negedge clk); drive(o_add, 1, 1);
    @(negedge clk); drive(o_add, 2, 2);
    @(negedge clk); drive(o_add, 3, 3); flush = 1'b1;
    #1 chk("flush_in_ready_comb", in_ready, 1);
    @(negedge clk); flush = 1'b0; in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1 chk("flush_quiet", out_valid, 0);
      @(negedge clk);
    end
    run_one("post_flush", o_add, 40, 2, 42, 0);

    o = '0; o.pack = 1'b1;
`ifdef BMU_PACK_EN
    run_one("pack", o, 32'h1111_2222, 32'h3333_4444, 32'h4444_2222, 0);
    o = '0; o.packh = 1'b1;
    run_one("packh", o, 32'h1111_2222, 32'h3333_4444, 32'h0000_4422, 0);
`else
    run_one("pack_off", o, 32'h1111_2222, 32'h3333_4444, 0, 1);
`endif

    // Reset pulsed mid-stream, asynchronously between clock edges.
    @(negedge clk); drive(o_add, 5, 6);
    @(negedge clk); drive(o_add, 7, 8);
    @(negedge clk); in_valid = 1'b0; out_ready = 1'b0;
    #1;
    chk("mid_pre_vld", out_valid, 1);
    chk("mid_pre_res", out_result, 11);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_vld", out_valid, 0);
    chk("mid_rst_res", out_result, 0);
    chk("mid_rst_err", out_error, 0);
    chk("mid_rst_rdy", in_ready, 1);
    @(negedge clk); rst = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1 chk("mid_rst_quiet", out_valid, 0);
      @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
